// File: rtl/fetch_predict.sv
// Fetch stage: owns the PC, predecodes the fetched word and predicts
// conditional branches with a bimodal table of 2-bit counters.
module fetch_predict #(
   parameter int unsigned           word_width  = 32,
   parameter logic [word_width-1:0] reset_pc    = '0,
   parameter int unsigned           bht_entries = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_stall,
   input  logic                  i_halt,
   input  logic                  i_branch,
   input  logic [word_width-1:0] i_branch_addr,
   input  logic                  i_upd_valid,
   input  logic                  i_upd_taken,
   input  logic [word_width-1:0] i_upd_pc,
   output logic [word_width-1:0] o_imem_addr,
   input  logic [word_width-1:0] i_imem_rdata,
   output logic [word_width-1:0] o_fetch_inst,
   output logic [word_width-1:0] o_fetch_pc,
   output logic                  o_fetch_valid,
   output logic                  o_fetch_pred_taken,
   output logic [word_width-1:0] o_stat_branches,
   output logic [word_width-1:0] o_stat_mispredicts
);

   localparam int unsigned IDX_W = $clog2(bht_entries);
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [1:0]  CTR_INIT  = 2'b01;

   logic [word_width-1:0] r_pc;
   logic                  r_halted;
   logic [1:0]            r_bht [bht_entries];
   logic [word_width-1:0] r_stat_br;
   logic [word_width-1:0] r_stat_mp;

   logic                  w_is_cond;
   logic [word_width-1:0] w_imm;
   logic [IDX_W-1:0]      w_idx;
   logic [IDX_W-1:0]      w_uidx;
   logic                  w_valid;
   logic                  w_pred;
   logic [word_width-1:0] w_pc_next;
   logic [1:0]            w_ctr_cur;
   logic [1:0]            w_ctr_next;
   logic                  w_br_full;
   logic                  w_mp_full;

   // predecode of the fetched word: conditional-branch flag and B-immediate
   assign w_is_cond = (i_imem_rdata[6:0] == OP_BRANCH);
   assign w_imm = {{(word_width-13){i_imem_rdata[31]}},
                   i_imem_rdata[31],
                   i_imem_rdata[7],
                   i_imem_rdata[30:25],
                   i_imem_rdata[11:8],
                   1'b0};

   // table indices drop the byte offset of word-aligned PCs
   assign w_idx  = r_pc[IDX_W+1:2];
   assign w_uidx = i_upd_pc[IDX_W+1:2];

   // the wrong-path word in a redirect cycle is squashed
   assign w_valid = ~r_halted & ~i_halt & ~i_branch & ~i_rst;
   assign w_pred  = w_is_cond & r_bht[w_idx][1] & w_valid;

   assign o_imem_addr        = r_pc;
   assign o_fetch_pc         = r_pc;
   assign o_fetch_inst       = i_imem_rdata;
   assign o_fetch_valid      = w_valid;
   assign o_fetch_pred_taken = w_pred;
   assign o_stat_branches    = r_stat_br;
   assign o_stat_mispredicts = r_stat_mp;

   assign w_br_full = &r_stat_br;
   assign w_mp_full = &r_stat_mp;

   // next-PC selection: redirect beats halt, halt beats stall, then prediction
   always_comb begin
      w_pc_next = r_pc + word_width'(4);
      if (i_branch) begin
         w_pc_next = i_branch_addr;
      end else if (r_halted | i_halt) begin
         w_pc_next = r_pc;
      end else if (i_stall) begin
         w_pc_next = r_pc;
      end else if (w_pred) begin
         w_pc_next = r_pc + w_imm;
      end
   end

   // saturating counter step for the entry being trained
   always_comb begin
      w_ctr_cur  = r_bht[w_uidx];
      w_ctr_next = w_ctr_cur;
      if (i_upd_taken) begin
         if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
      end else begin
         if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
      end
   end

   // program counter and sticky halt flag
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc     <= reset_pc;
         r_halted <= 1'b0;
      end else begin
         r_pc <= w_pc_next;
         if (i_halt) r_halted <= 1'b1;
      end
   end

   // branch history table; training ignores stall and halt, no read bypass
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < int'(bht_entries); i++) begin
            r_bht[i] <= CTR_INIT;
         end
      end else if (i_upd_valid) begin
         r_bht[w_uidx] <= w_ctr_next;
      end
   end

   // saturating branch and mispredict statistics
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else if (i_upd_valid) begin
         if (!w_br_full) r_stat_br <= r_stat_br + word_width'(1);
         if (i_branch && !w_mp_full) r_stat_mp <= r_stat_mp + word_width'(1);
      end
   end

endmodule

// File: tb/tb_fetch_predict.sv
// Scoreboard bench for fetch_predict: random and directed stimulus
// against a behavioural model of PC, predictor and statistics.
module tb_fetch_predict;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] BEQ = 32'hFE000EE3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        halt = 1'b0;
   logic        branch = 1'b0;
   logic [31:0] branch_addr = '0;
   logic        upd_valid = 1'b0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_pc = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = NOP;
   logic [31:0] fetch_inst;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        fetch_pred_taken;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   fetch_predict #(
      .word_width(32),
      .reset_pc(32'h0),
      .bht_entries(64)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_stall(stall),
      .i_halt(halt),
      .i_branch(branch),
      .i_branch_addr(branch_addr),
      .i_upd_valid(upd_valid),
      .i_upd_taken(upd_taken),
      .i_upd_pc(upd_pc),
      .o_imem_addr(imem_addr),
      .i_imem_rdata(imem_rdata),
      .o_fetch_inst(fetch_inst),
      .o_fetch_pc(fetch_pc),
      .o_fetch_valid(fetch_valid),
      .o_fetch_pred_taken(fetch_pred_taken),
      .o_stat_branches(stat_branches),
      .o_stat_mispredicts(stat_mispredicts)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred;
      logic [31:0] nbr;
      logic [31:0] nmp;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // behavioural model state
   logic [31:0] m_pc;
   bit          m_halted;
   int          m_ctr [64];
   logic [31:0] m_br;
   logic [31:0] m_mp;

   function automatic void model_reset();
      m_pc = 32'h0;
      m_halted = 0;
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_br = 0;
      m_mp = 0;
   endfunction

   function automatic int slot(input logic [31:0] a);
      return int'((a / 4) % 64);
   endfunction

   function automatic logic [31:0] b_imm(input logic [31:0] w);
      int v;
      v = w[31] ? -4096 : 0;
      v += int'(w[7]) * 2048;
      v += int'(w[30:25]) * 32;
      v += int'(w[11:8]) * 2;
      return 32'(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // monitor: one expected entry per cycle, compared after the inputs settle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         while (q.size() > 0) begin
            e = q.pop_front();
            chk("fetch_valid", 32'(fetch_valid), 32'(e.valid));
            chk("fetch_pc", fetch_pc, e.pc);
            chk("imem_addr", imem_addr, e.pc);
            chk("fetch_inst", fetch_inst, e.inst);
            chk("pred_taken", 32'(fetch_pred_taken), 32'(e.pred));
            chk("stat_branches", stat_branches, e.nbr);
            chk("stat_mispredicts", stat_mispredicts, e.nmp);
         end
      end
   end

   // one fetch cycle: drive, predict the response, then advance the model
   task automatic cyc(input bit r, input bit s, input bit h, input bit b,
                      input logic [31:0] ba, input bit uv, input bit ut,
                      input logic [31:0] up, input logic [31:0] inst);
      exp_t e;
      bit   take;
      @(negedge clk);
      rst = r; stall = s; halt = h; branch = b; branch_addr = ba;
      upd_valid = uv; upd_taken = ut; upd_pc = up; imem_rdata = inst;
      if (r) model_reset();
      e.valid = !m_halted && !h && !b && !r;
      e.pc    = m_pc;
      e.inst  = inst;
      take    = (inst[6:0] == 7'h63) && (m_ctr[slot(m_pc)] >= 2);
      e.pred  = e.valid && take;
      e.nbr   = m_br;
      e.nmp   = m_mp;
      q.push_back(e);
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         if (b) m_pc = ba;
         else if (m_halted || h || s) m_pc = m_pc;
         else if (e.pred) m_pc = m_pc + b_imm(inst);
         else m_pc = m_pc + 4;
         if (h) m_halted = 1;
         if (uv) begin
            if (ut) m_ctr[slot(up)] = (m_ctr[slot(up)] == 3) ? 3 : m_ctr[slot(up)] + 1;
            else    m_ctr[slot(up)] = (m_ctr[slot(up)] == 0) ? 0 : m_ctr[slot(up)] - 1;
            if (m_br != 32'hFFFFFFFF) m_br = m_br + 1;
            if (b && m_mp != 32'hFFFFFFFF) m_mp = m_mp + 1;
         end
      end
   endtask

   task automatic nop();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, NOP);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, NOP);
   endtask

   task automatic run_to(input logic [31:0] t);
      for (int k = 0; k < 80 && m_pc != t; k++) nop();
      n_chk++;
      if (m_pc != t) begin
         n_fail++;
         $display("FAIL run_to: pc %h target %h", m_pc, t);
      end
   endtask

   task automatic rand_cycle();
      bit          b, h, s, uv;
      logic [31:0] inst, ba, up;
      s  = ($urandom_range(0, 3) == 0);
      h  = ($urandom_range(0, 149) == 0);
      b  = ($urandom_range(0, 7) == 0);
      uv = ($urandom_range(0, 2) == 0);
      ba = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom_range(0, 255) * 4);
      up = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom_range(0, 127) * 4);
      inst = $urandom();
      inst[6:0] = ($urandom_range(0, 1) == 0) ? 7'h63 : 7'h13;
      cyc(0, s, h, b, ba, uv, $urandom_range(0, 1) == 1, up, inst);
   endtask

   initial begin
      model_reset();
      // reset, sequential fetch, mid-cycle reset
      do_reset();
      repeat (4) nop();
      do_reset();
      nop();
      // training one update flips a weak counter to taken
      do_reset();
      cyc(0, 0, 0, 0, 0, 1, 1, 32'h10, NOP);
      run_to(32'h10);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, BEQ);
      nop();
      // mispredict redirect at 0x20
      do_reset();
      run_to(32'h20);
      cyc(0, 0, 0, 1, 32'h100, 1, 1, 32'h20, NOP);
      nop();
      // stall hold, then stall with redirect
      repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0, NOP);
      cyc(0, 1, 0, 1, 32'h40, 0, 0, 0, NOP);
      nop();
      // saturation at both ends and lookup/update collision on index 3
      do_reset();
      repeat (5) cyc(0, 1, 0, 0, 0, 1, 1, 32'hC, NOP);
      run_to(32'hC);
      cyc(0, 0, 0, 0, 0, 1, 0, 32'hC, BEQ);
      repeat (4) cyc(0, 1, 0, 0, 0, 1, 0, 32'hC, NOP);
      run_to(32'hC);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, BEQ);
      cyc(0, 0, 0, 0, 0, 1, 1, 32'hC, NOP);
      run_to(32'h20);
      // halt is sticky; a redirect still moves the PC
      do_reset();
      run_to(32'h8);
      cyc(0, 0, 1, 0, 0, 0, 0, 0, NOP);
      repeat (3) nop();
      cyc(0, 0, 0, 1, 32'h200, 1, 0, 32'h8, NOP);
      repeat (2) nop();
      do_reset();
      nop();
      // randomized segments with wrap-around targets
      for (int seg = 0; seg < 8; seg++) begin
         do_reset();
         if (seg == 7) cyc(0, 0, 0, 1, 32'hFFFFFFF8, 0, 0, 0, NOP);
         for (int n = 0; n < 250; n++) rand_cycle();
      end
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_predict.md
Name: fetch_predict

Overview:
- Fetch stage that owns the program counter and sits directly upstream of decode and the branch-resolution stage.
- Every cycle it presents the PC to instruction memory and predecodes the returned word. It predicts conditional branches with a bimodal table of 2-bit saturating counters and tags each fetched instruction with its prediction, which becomes `is_pred_branch` downstream.
- It consumes the resolution stage's redirect (`branch`, `branch_addr`) and training signals (`is_branch_op`, `branch_taken`), and keeps branch and mispredict statistics.

Parameters:
- `word_width`, 32, width of PC, instruction and statistic counters.
- `reset_pc`, 32'b0, PC value loaded on reset.
- `bht_entries`, 64, number of 2-bit counters; must be a power of two ≥ 2.

Ports:
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `stall` input 1: downstream back-pressure; hold PC.
- `halt` input 1: stop fetching; sticky until reset.
- `branch` input 1: redirect request from branch resolution.
- `branch_addr` input word_width: redirect target; valid when `branch`=1.
- `upd_valid` input 1: a conditional branch resolved this cycle (`is_branch_op`).
- `upd_taken` input 1: resolved outcome (`branch_taken`).
- `upd_pc` input word_width: `inst_addr` of the resolved branch.
- `imem_addr` output word_width: equals `pc_q`.
- `imem_rdata` input word_width: instruction at `imem_addr`, same cycle (combinational memory).
- `fetch_inst` output word_width: equals `imem_rdata`.
- `fetch_pc` output word_width: equals `pc_q`.
- `fetch_valid` output 1: `fetch_inst`/`fetch_pc` are valid to decode.
- `fetch_pred_taken` output 1: prediction for the fetched instruction.
- `stat_branches` output word_width: resolved conditional branches.
- `stat_mispredicts` output word_width: resolved conditional branches with `branch`=1.

Behaviour:
- **Reset (async, any time):**
  - `pc_q`=`reset_pc`; `halted_q`=0.
  - All BHT counters = 2'b01 (weakly not-taken).
  - Both statistic counters = 0.
- **Outputs:** all are combinational from state and inputs, so fetch latency is 0 cycles.
  - `fetch_valid` = ~`halted_q` & ~`halt` & ~`branch` & ~`rst`. The wrong-path instruction in the redirect cycle is squashed.
- **Predecode:**
  - `is_cond` = (`imem_rdata[6:0]` == 7'b1100011).
  - B-immediate = sign-extend of {`inst[31]`, `inst[7]`, `inst[30:25]`, `inst[11:8]`, 1'b0} to word_width.
- **Lookup:**
  - `idx` = `pc_q[log2(bht_entries)+1:2]`.
  - `fetch_pred_taken` = `is_cond` & `bht[idx][1]` & `fetch_valid`.
- **Next-PC priority, highest first:**
  1. `branch`=1 → `branch_addr`. Wins over `stall` and `halt`.
  2. `halted_q` | `halt` → hold.
  3. `stall` → hold.
  4. `fetch_pred_taken` → `pc_q` + B-immediate.
  5. Otherwise → `pc_q` + 4.
- **Halt:**
  - `halt`=1 sets `halted_q` on the same edge. It remains set until `rst`.
  - A `branch` coinciding with `halt` still loads `pc_q`.
- **Arithmetic:** all PC addition is modulo 2^word_width with no overflow detection. Targets are stored verbatim; no alignment check.
- **BHT update (on edge, when `upd_valid`):**
  - `uidx` = `upd_pc[log2(bht_entries)+1:2]`.
  - Counter increments if `upd_taken`, else decrements.
  - Saturates at 2'b11 and 2'b00.
- **BHT read/update collision:** update is independent of `stall`/`halt`. A lookup and update to the same index in one cycle returns the pre-update value; there is no bypass.
- **Statistics:**
  - `stat_branches` increments on `upd_valid`.
  - `stat_mispredicts` increments on `upd_valid` & `branch`.
  - Both saturate at all-ones and are not blocked by `halt`.
- **Storage:** the BHT is a flop array so the reset requirement holds; no SRAM.

Test Plan:
- **Reset and sequential fetch:** assert `rst`, release, feed NOPs (32'h00000013).
  - Expect `fetch_pc` 0, 4, 8, 12 on consecutive cycles with `fetch_valid`=1 and `fetch_pred_taken`=0.
  - Assert `rst` mid-cycle → `fetch_pc` returns to 0 immediately.
- **Training to predicted-taken:**
  - Pulse `upd_valid`=1, `upd_taken`=1, `upd_pc`=0x10 once → counter 2'b10.
  - Fetch at 0x10 with `imem_rdata`=32'hFE000EE3 (beq x0,x0,-4) → `fetch_pred_taken`=1 and next `fetch_pc`=0x0C.
- **Mispredict redirect:**
  - At PC 0x20, assert `branch`=1, `branch_addr`=0x100, `upd_valid`=1.
  - Expect `fetch_valid`=0 that cycle, `fetch_pc`=0x100 next cycle, `stat_branches`=1, `stat_mispredicts`=1.
- **Stall versus redirect:**
  - `stall`=1 for 3 cycles → `fetch_pc` held.
  - `stall`=1 with `branch`=1, `branch_addr`=0x40 → next `fetch_pc`=0x40.
- **Saturation and collision:**
  - 5 taken updates to index 3 → counter stays 2'b11; 5 not-taken updates → 2'b00.
  - A same-cycle lookup of index 3 during the first not-taken update still predicts taken.
- **Halt:**
  - Assert `halt` at PC 0x8 → `fetch_valid`=0 from that cycle.
  - PC stays 0x8 after `halt` is deasserted, until `rst`.
